// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring 32-bit divider for the EX stage
//
// Purpose:
//   Divides srca by srcb (signed DIV or unsigned DIVU), one quotient bit per
//   cycle, stalling IF/ID/EX while it iterates. Results feed the HI/LO write.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   alucontrolE  EX-stage ALU control; SIG_ALU_DIV / SIG_ALU_DIVU select this unit
//   validE       EX holds a live instruction
//   flushE       annul the EX instruction; aborts a divide in progress
//   srca         dividend (rs)
//   srcb         divisor (rt)
//   stall_div    freeze IF/ID/EX (combinational)
//   done         one-cycle pulse; hi_o/lo_o valid for the HI/LO write
//   hi_o         remainder
//   lo_o         quotient
//
// Configuration:
//   DIV_ZERO_FAST_EN  when defined, a zero divisor skips the iterations and
//                     completes the cycle after accept.

// Fallback ALU codes for builds that do not pull in the decoder header.
`ifndef SIG_ALU_DIV
`define SIG_ALU_DIV  5'b11010
`endif
`ifndef SIG_ALU_DIVU
`define SIG_ALU_DIVU 5'b11011
`endif

module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       alucontrolE,
  input  logic             validE,
  input  logic             flushE,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             stall_div,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd;      // dividend shifting out MSB-first; quotient shifts in at LSB
  logic [WIDTH-1:0] dsr;      // |divisor|
  logic [WIDTH-1:0] rem;      // partial remainder
  logic [WIDTH-1:0] a_orig;   // untouched dividend, returned as HI on divide by zero
  logic             sign_q;
  logic             sign_r;
  logic             div0;

  logic             is_div;
  logic             is_divs;
  logic             start;
  logic             b_zero;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] dvd_nxt;
  logic             last;
  logic [WIDTH-1:0] lo_fin;
  logic [WIDTH-1:0] hi_fin;

  // Decode and accept
  assign is_divs = (alucontrolE == `SIG_ALU_DIV);
  assign is_div  = is_divs | (alucontrolE == `SIG_ALU_DIVU);
  assign start   = (state == IDLE) & validE & ~flushE & is_div;
  assign b_zero  = (srcb == '0);

  // Absolute values only in signed mode; the most negative value maps onto
  // itself, which read as unsigned is exactly its magnitude.
  assign abs_a = (is_divs && srca[WIDTH-1]) ? -srca : srca;
  assign abs_b = (is_divs && srcb[WIDTH-1]) ? -srcb : srcb;

  // One restoring step: the trial remainder needs one extra bit because the
  // shifted remainder can exceed WIDTH bits before the subtract.
  assign trial   = {rem, dvd[WIDTH-1]};
  assign diff    = trial - {1'b0, dsr};
  assign ge      = (trial >= {1'b0, dsr});
  assign rem_nxt = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign dvd_nxt = {dvd[WIDTH-2:0], ge};
  assign last    = (count == LAST_COUNT);

  // Sign correction; a zero divisor bypasses it with fixed results.
  always_comb begin
    lo_fin = sign_q ? -dvd_nxt : dvd_nxt;
    hi_fin = sign_r ? -rem_nxt : rem_nxt;
    if (div0) begin
      lo_fin = '1;
      hi_fin = a_orig;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef DIV_ZERO_FAST_EN
          state_nxt = b_zero ? DONE : BUSY;
`else
          state_nxt = BUSY;
`endif
        end
      end
      BUSY: begin
        if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flushE) state_nxt = IDLE;
  end

  // start is combinational from the inputs, so hold stall low while in reset.
  assign stall_div = ~rst & (start | (state == BUSY));
  assign done      = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      dvd    <= '0;
      dsr    <= '0;
      rem    <= '0;
      a_orig <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      div0   <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else begin
      if (start) begin
        count  <= '0;
        dvd    <= abs_a;
        dsr    <= abs_b;
        rem    <= '0;
        a_orig <= srca;
        sign_q <= is_divs & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
        sign_r <= is_divs & srca[WIDTH-1];
        div0   <= b_zero;
`ifdef DIV_ZERO_FAST_EN
        if (b_zero) begin
          lo_o <= '1;
          hi_o <= srca;
        end
`endif
      end else if (state == BUSY) begin
        count <= count + CW'(1);
        dvd   <= dvd_nxt;
        rem   <= rem_nxt;
        // A flush on the final iteration aborts, so results stay untouched.
        if (last && !flushE) begin
          lo_o <= lo_fin;
          hi_o <= hi_fin;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
`ifndef SIG_ALU_DIV
`define SIG_ALU_DIV  5'b11010
`endif
`ifndef SIG_ALU_DIVU
`define SIG_ALU_DIVU 5'b11011
`endif

module tb_div_unit;

  localparam logic [4:0] OP_DIV  = `SIG_ALU_DIV;
  localparam logic [4:0] OP_DIVU = `SIG_ALU_DIVU;
  localparam logic [4:0] OP_ADD  = 5'b00010;
`ifdef DIV_ZERO_FAST_EN
  localparam int LAT_ZERO = 1;
`else
  localparam int LAT_ZERO = 33;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  alucontrolE;
  logic        validE;
  logic        flushE;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        stall_div;
  logic        done;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .alucontrolE (alucontrolE),
    .validE      (validE),
    .flushE      (flushE),
    .srca        (srca),
    .srcb        (srcb),
    .stall_div   (stall_div),
    .done        (done),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Presents a divide at the current negedge (cycle T) and holds it until done.
  // Returns at the negedge of the done cycle with the instruction still in EX.
  task automatic run_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic stall_ok);
    alucontrolE = op;
    srca        = a;
    srcb        = b;
    validE      = 1'b1;
    flushE      = 1'b0;
    #1;
    stall_ok = (stall_div === 1'b1);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) begin
        lat = k;
        if (stall_div !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (stall_div !== 1'b1) stall_ok = 1'b0;
    end
  endtask

  initial begin
    int          lat;
    int          lat_expect;
    logic        stall_ok;
    logic [31:0] keep_lo;
    logic [31:0] keep_hi;
    logic        seen;

    vecs[0] = '{"divu_100_7",     OP_DIVU, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1] = '{"div_m7_2",       OP_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
    vecs[2] = '{"div_7_m2",       OP_DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
    vecs[3] = '{"div_ovf",        OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
    vecs[4] = '{"divu_ovf_ops",   OP_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000};
    vecs[5] = '{"divu_5_0",       OP_DIVU, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5};
    vecs[6] = '{"div_m5_0",       OP_DIV,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB};
    vecs[7] = '{"div_m100_m7",    OP_DIV,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE};
    vecs[8] = '{"divu_max_1",     OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0};
    vecs[9] = '{"divu_1000_1000", OP_DIVU, 32'd1000,       32'd1000,       32'd1,          32'd0};

    // Reset with a divide already presented: nothing may stall or start.
    rst = 1'b1; validE = 1'b1; flushE = 1'b0;
    alucontrolE = OP_DIVU; srca = 32'd10; srcb = 32'd3;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_stall", {31'd0, stall_div}, 32'd0);
    chk("reset_done",  {31'd0, done},      32'd0);
    chk("reset_lo",    lo_o,               32'd0);
    chk("reset_hi",    hi_o,               32'd0);
    validE = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Non-divide code keeps the unit idle.
    @(negedge clk);
    alucontrolE = OP_ADD; validE = 1'b1; srca = 32'd1; srcb = 32'd2;
    #1;
    chk("nondiv_stall", {31'd0, stall_div}, 32'd0);
    @(negedge clk);
    #1;
    chk("nondiv_stall2", {31'd0, stall_div}, 32'd0);
    chk("nondiv_done",   {31'd0, done},      32'd0);
    validE = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      run_div(vecs[i].op, vecs[i].a, vecs[i].b, lat, stall_ok);
      lat_expect = (vecs[i].b == 32'd0) ? LAT_ZERO : 33;
      chk({vecs[i].name, "_lat"},   lat,              lat_expect);
      chk({vecs[i].name, "_stall"}, {31'd0, stall_ok}, 32'd1);
      chk({vecs[i].name, "_lo"},    lo_o,             vecs[i].lo);
      chk({vecs[i].name, "_hi"},    hi_o,             vecs[i].hi);
      @(negedge clk);
      validE = 1'b0; alucontrolE = OP_ADD;
      #1;
      chk({vecs[i].name, "_done_1cyc"}, {31'd0, done}, 32'd0);
    end

    // Back-to-back: second divide enters EX the cycle after DONE.
    @(negedge clk);
    run_div(OP_DIVU, 32'd9, 32'd4, lat, stall_ok);
    chk("b2b1_lat",   lat,               33);
    chk("b2b1_stall", {31'd0, stall_ok}, 32'd1);
    chk("b2b1_lo",    lo_o,              32'd2);
    chk("b2b1_hi",    hi_o,              32'd1);
    @(negedge clk);
    run_div(OP_DIVU, 32'd20, 32'd6, lat, stall_ok);
    chk("b2b2_gap",   lat + 1,           34);
    chk("b2b2_stall", {31'd0, stall_ok}, 32'd1);
    chk("b2b2_lo",    lo_o,              32'd3);
    chk("b2b2_hi",    hi_o,              32'd2);
    @(negedge clk);
    validE = 1'b0;

    // Flush mid-divide: abort, no done, results unchanged.
    keep_lo = 32'd3; keep_hi = 32'd2;
    @(negedge clk);
    alucontrolE = OP_DIVU; srca = 32'd50; srcb = 32'd5; validE = 1'b1; flushE = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    flushE = 1'b1;
    @(negedge clk);
    flushE = 1'b0; validE = 1'b0;
    #1;
    chk("flush_stall", {31'd0, stall_div}, 32'd0);
    chk("flush_done",  {31'd0, done},      32'd0);
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done === 1'b1 || stall_div === 1'b1) seen = 1'b1;
    end
    chk("flush_no_done", {31'd0, seen}, 32'd0);
    chk("flush_lo",      lo_o,          keep_lo);
    chk("flush_hi",      hi_o,          keep_hi);

    // Reset mid-divide: all outputs cleared.
    @(negedge clk);
    alucontrolE = OP_DIVU; srca = 32'd50; srcb = 32'd5; validE = 1'b1;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_stall", {31'd0, stall_div}, 32'd0);
    chk("rstmid_done",  {31'd0, done},      32'd0);
    chk("rstmid_lo",    lo_o,               32'd0);
    chk("rstmid_hi",    hi_o,               32'd0);
    validE = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Unit works again after the reset.
    @(negedge clk);
    run_div(OP_DIVU, 32'd50, 32'd5, lat, stall_ok);
    chk("post_rst_lat", lat,  33);
    chk("post_rst_lo",  lo_o, 32'd10);
    chk("post_rst_hi",  hi_o, 32'd0);
    @(negedge clk);
    validE = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider in the EX stage, directly downstream of the ALU-control decoder.
- Consumes the 5-bit alucontrol code for DIV/DIVU and the two operands.
- Stalls the pipeline while it iterates, then presents quotient/remainder for the HI/LO write.
- Uses a radix-2 restoring algorithm: one quotient bit per cycle.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported; the parameter exists for bench reuse at 8.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- alucontrolE  input  5  EX-stage ALU control; `SIG_ALU_DIV (signed) and `SIG_ALU_DIVU (unsigned) from define_alu_ctrl.vh select this unit
- validE  input  1  EX holds a live instruction
- flushE  input  1  annul the EX instruction; aborts any divide in progress
- srca  input  WIDTH  dividend (rs)
- srcb  input  WIDTH  divisor (rt)
- stall_div  output  1  freeze IF/ID/EX; combinational
- done  output  1  one-cycle pulse; hi_o/lo_o are valid for HI/LO write
- hi_o  output  WIDTH  remainder
- lo_o  output  WIDTH  quotient

Behaviour:
- Reset: state IDLE; hi_o = lo_o = 0; done = 0; stall_div = 0 while rst is high. Reset mid-divide discards all progress.
- start = (state == IDLE) & validE & ~flushE & (alucontrolE == DIV | DIVU).
- stall_div = start | (state == BUSY). It is 0 in IDLE (without start) and in DONE.
- FSM states: IDLE, BUSY, DONE.
  - IDLE --start--> BUSY.
  - BUSY: 32 iterations, counter 0..31; on count 31 --> DONE.
  - DONE --> IDLE unconditionally. An instruction still in EX during DONE never restarts the unit.
  - flushE in any state --> IDLE next cycle. done is not pulsed and hi_o/lo_o hold their prior values.
- Accept cycle (start high):
  - Latch signed-mode flag, sign_q = a[31]^b[31], sign_r = a[31], div0 = (b == 0).
  - Latch |a| and |b|; absolute values only in signed mode.
- Iteration: remainder = {rem, dividend MSB} shifted left by one. If remainder >= divisor, subtract and set the quotient bit to 1.
- Latency: accept at cycle T; BUSY T+1..T+32; done = 1 at T+33 with stall_div = 0, so the pipeline advances that edge.
- hi_o/lo_o are registered on entry to DONE and hold until the next completion.
- Signed correction:
  - lo = sign_q ? -q : q.
  - hi = sign_r ? -r : r.
  - The remainder always takes the dividend's sign.
- Overflow: 0x80000000 / 0xFFFFFFFF (signed) gives lo = 0x80000000, hi = 0. No trap.
- Divide by zero (either mode): lo = 0xFFFFFFFF, hi = srca as latched (original, not abs). Signed correction is suppressed.
- Back-to-back divides: a second DIV in EX the cycle after DONE sees IDLE and starts normally.
- Non-divide alucontrol codes: unit stays IDLE; stall_div = 0.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined: if div0 at accept, go IDLE -> DONE directly. done rises at T+1, stall_div is high only in cycle T, and the results are the divide-by-zero values above.
- Undefined: divide by zero runs the full 33-cycle sequence, with identical hi_o/lo_o values.

Test Plan:
- DIVU 100 / 7 with validE held → stall_div high T..T+32, done at T+33, lo_o = 14, hi_o = 2.
- DIV -7 / 2 (0xFFFFFFF9 / 2) → lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF. Also DIV 7 / -2 → lo_o = 0xFFFFFFFD, hi_o = 1.
- DIV 0x80000000 / 0xFFFFFFFF → lo_o = 0x80000000, hi_o = 0. DIVU same operands → lo_o = 0, hi_o = 0x80000000.
- DIVU 5 / 0 → lo_o = 0xFFFFFFFF, hi_o = 5. done at T+33, or at T+1 with DIV_ZERO_FAST_EN.
- Start DIVU 50/5, assert flushE at T+10 → IDLE at T+11, stall_div = 0, no done, hi_o/lo_o unchanged. Repeat with rst pulsed at T+10 → all outputs 0.
- Two consecutive DIVU (9/4 then 20/6) → done pulses 34 cycles apart; results lo/hi = 2/1 then 3/2. No restart in the DONE cycle.
